// File: rtl/bshift_pkg.sv
// Shared types and constants for the button-driven shift/rotate engine.
package bshift_pkg;

  localparam int unsigned OPCNT_W = 16;

  typedef enum logic [1:0] {
    LOGIC,
    ARITH,
    ROT,
    ROTC
  } mode_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    LOAD,
    LEFT,
    RIGHT
  } cmd_t;

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, debounce, registered rising-edge press pulse.
// Define BSHIFT_DEBOUNCE_BYPASS_EN to drop the debounce counter (level = synchroniser output).
module btn_conditioner #(
  parameter int unsigned DEB_CYCLES = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  logic sync1_q, sync2_q;
  logic prev_q, press_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      prev_q  <= level;
      press_q <= level & ~prev_q;
    end
  end

  assign press = press_q;

`ifdef BSHIFT_DEBOUNCE_BYPASS_EN
  assign level = sync2_q;
`else
  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;

  // Level flips only after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
`endif

endmodule

// File: rtl/btn_shift_engine.sv
// Button-driven serial shift/rotate engine: loads from switches, shifts one bit per clock
// per accepted press, in logical, arithmetic, rotate or rotate-through-carry mode.
module btn_shift_engine
  import bshift_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEB_CYCLES = 100000,
  parameter int unsigned SHAMT_W    = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               btn_l,
  input  logic               btn_r,
  input  logic               btn_ld,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   val_in,
  output logic [WIDTH-1:0]   res,
  output logic               carry,
  output logic               busy,
  output logic               done,
  output logic [OPCNT_W-1:0] op_cnt
);

  logic       press_l, press_r, press_ld;
  logic [2:0] unused_lvl;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_l (
    .clock (clock),
    .reset (reset),
    .raw   (btn_l),
    .level (unused_lvl[0]),
    .press (press_l)
  );

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_r (
    .clock (clock),
    .reset (reset),
    .raw   (btn_r),
    .level (unused_lvl[1]),
    .press (press_r)
  );

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_ld (
    .clock (clock),
    .reset (reset),
    .raw   (btn_ld),
    .level (unused_lvl[2]),
    .press (press_ld)
  );

  // One-position step; returns {carry_out, result}.
  function automatic logic [WIDTH:0] step_fn(input logic [WIDTH-1:0] r, input logic c,
                                             input logic left, input mode_t m);
    logic [WIDTH-1:0] r_n;
    logic             c_n;
    if (left) begin
      c_n = r[WIDTH-1];
      case (m)
        ROT:     r_n = {r[WIDTH-2:0], r[WIDTH-1]};
        ROTC:    r_n = {r[WIDTH-2:0], c};
        default: r_n = {r[WIDTH-2:0], 1'b0};
      endcase
    end else begin
      c_n = r[0];
      case (m)
        ARITH:   r_n = {r[WIDTH-1], r[WIDTH-1:1]};
        ROT:     r_n = {r[0], r[WIDTH-1:1]};
        ROTC:    r_n = {c, r[WIDTH-1:1]};
        default: r_n = {1'b0, r[WIDTH-1:1]};
      endcase
    end
    return {c_n, r_n};
  endfunction

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 carry_q, carry_d;
  logic                 left_q, left_d;
  mode_t                mode_q, mode_d;
  logic [SHAMT_W-1:0]   rem_q, rem_d;
  logic [OPCNT_W-1:0]   op_cnt_q, op_cnt_d;
  cmd_t                 cmd;

  always_comb begin
    cmd = NONE;
    if (press_ld) begin
      cmd = LOAD;
    end else if (press_l) begin
      cmd = LEFT;
    end else if (press_r) begin
      cmd = RIGHT;
    end
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    carry_d  = carry_q;
    left_d   = left_q;
    mode_d   = mode_q;
    rem_d    = rem_q;
    op_cnt_d = op_cnt_q;
    if (cmd == LOAD) begin
      res_d   = val_in;
      carry_d = 1'b0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if ((cmd == LEFT || cmd == RIGHT) && shamt != '0) begin
            left_d  = (cmd == LEFT);
            mode_d  = mode_t'(mode);
            rem_d   = shamt;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          {carry_d, res_d} = step_fn(res_q, carry_q, left_q, mode_q);
          rem_d            = rem_q - 1'b1;
          if (rem_q == SHAMT_W'(1)) begin
            state_d  = DONE;
            op_cnt_d = op_cnt_q + 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      res_q    <= '0;
      carry_q  <= 1'b0;
      left_q   <= 1'b0;
      mode_q   <= LOGIC;
      rem_q    <= '0;
      op_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      left_q   <= left_d;
      mode_q   <= mode_d;
      rem_q    <= rem_d;
      op_cnt_q <= op_cnt_d;
    end
  end

  assign res    = res_q;
  assign carry  = carry_q;
  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign op_cnt = op_cnt_q;

endmodule
